binary_to_bcd_seq: RTL and testbench

BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/binary_to_bcd_seq.sv | 119 +++++++++++
 tb/tb_binary_to_bcd_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned ADD3_THRESH = 5;

    // ceil(n * log10(2)), with 30103/100000 standing in for log10(2)
    function automatic int unsigned min_digits(input int unsigned n);
        return (n * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_W'(ADD3_THRESH)) begin
            digit_out = digit_in + BCD_W'(3);
        end
    end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter with valid/ready handshakes.
// Define BIN_TO_BCD_SIGNED_EN to treat bin_in as two's complement (sign on neg).
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          bin_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CNT_W = $clog2(N + 1);
    localparam int SCR_W = BCD_W * DIGITS;

    state_e             state_q, state_d;
    logic [N-1:0]       bin_q, bin_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [SCR_W-1:0]   scr_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SCR_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               neg_q, neg_d;

    logic [N-1:0]       cap_mag;
    logic               cap_sign;

`ifdef BIN_TO_BCD_SIGNED_EN
    // Magnitude of the most negative value still fits in N unsigned bits.
    assign cap_sign = bin_in[N-1];
    assign cap_mag  = bin_in[N-1] ? -bin_in : bin_in;
`else
    assign cap_sign = 1'b0;
    assign cap_mag  = bin_in;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scr_q[g*BCD_W +: BCD_W]),
            .digit_out (scr_adj[g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d = state_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        neg_d   = neg_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = cap_mag;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(N);
                    sign_d  = cap_sign;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // N shift steps, then one edge to publish the result register.
                if (cnt_q != '0) begin
                    {scr_d, bin_d} = {scr_adj, bin_q} << 1;
                    cnt_d          = cnt_q - CNT_W'(1);
                end else begin
                    bcd_d   = scr_q;
                    neg_d   = sign_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    bcd_d   = '0;
                    neg_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            neg_q   <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign neg       = neg_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: per-cycle model comparison plus
// directed literal checks (signed checks only when BIN_TO_BCD_SIGNED_EN is defined).
module tb_binary_to_bcd_seq;

    localparam int N      = 8;
    localparam int DIGITS = 3;
    localparam int LAT    = N + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        bin_in;
    logic                in_valid;
    logic                in_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                neg;
    logic                out_valid;
    logic                out_ready;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    binary_to_bcd_seq #(.N(N), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .bin_in    (bin_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .neg       (neg),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int unsigned ref_mag(input logic [N-1:0] b);
`ifdef BIN_TO_BCD_SIGNED_EN
        return b[N-1] ? (2**N - int'(b)) : int'(b);
`else
        return int'(b);
`endif
    endfunction

    function automatic bit ref_neg(input logic [N-1:0] b);
`ifdef BIN_TO_BCD_SIGNED_EN
        return b[N-1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit digits_ok(input logic [4*DIGITS-1:0] b);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Transaction-level model: one operand in flight, result visible LAT edges after acceptance.
    bit                  m_busy = 1'b0;
    int                  m_age  = 0;
    logic [4*DIGITS-1:0] m_bcd  = '0;
    bit                  m_neg  = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_bcd  <= ref_bcd(ref_mag(bin_in));
                m_neg  <= ref_neg(bin_in);
            end
        end else if (m_age >= LAT && out_ready) begin
            m_busy <= 1'b0;
        end else begin
            m_age <= m_age + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_in_ready",  in_ready,  !m_busy);
            check("cycle_out_valid", out_valid, m_busy && m_age >= LAT);
            check("cycle_bcd_out",   bcd_out,   (m_busy && m_age >= LAT) ? m_bcd : '0);
            check("cycle_neg",       neg,       (m_busy && m_age >= LAT) ? m_neg : 1'b0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("wait_out_valid", out_valid, 1'b1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_conv(input logic [N-1:0] v, output logic [4*DIGITS-1:0] got,
                           output logic got_neg, output int lat);
        @(negedge clk);
        bin_in   = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        got     = bcd_out;
        got_neg = neg;
        consume();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*DIGITS-1:0] got;
        logic                gneg;
        int                  lat;
        bit                  saw_valid;

        reset     = 1'b1;
        bin_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready",  in_ready,  1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_bcd_out",   bcd_out,   '0);
        check("reset_neg",       neg,       1'b0);
        chk_en = 1'b1;
        reset  = 1'b0;

`ifndef BIN_TO_BCD_SIGNED_EN
        do_conv(8'd255, got, gneg, lat);
        check("max_latency", lat, LAT);
        check("max_bcd", got, 12'h255);
        check("max_neg", gneg, 1'b0);
        do_conv(8'd0, got, gneg, lat);
        check("zero_bcd", got, 12'h000);
        do_conv(8'd99, got, gneg, lat);
        check("n99_bcd", got, 12'h099);
        do_conv(8'd100, got, gneg, lat);
        check("n100_bcd", got, 12'h100);

        // Second operand offered while busy must be ignored; result held under back-pressure.
        @(negedge clk);
        bin_in   = 8'd123;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bin_in = 8'd45;
        wait_out(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("hold_bcd_%0d", i), bcd_out, 12'h123);
            check($sformatf("hold_valid_%0d", i), out_valid, 1'b1);
            check($sformatf("hold_in_ready_%0d", i), in_ready, 1'b0);
        end
        in_valid = 1'b0;
        consume();
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("dropped_second", saw_valid, 1'b0);

        // Abort mid-conversion.
        @(negedge clk);
        bin_in   = 8'd200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        saw_valid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", saw_valid, 1'b0);
        do_conv(8'd37, got, gneg, lat);
        check("after_abort_bcd", got, 12'h037);
`else
        do_conv(8'h80, got, gneg, lat);
        check("s_min_bcd", got, 12'h128);
        check("s_min_neg", gneg, 1'b1);
        check("s_latency", lat, LAT);
        do_conv(8'hFF, got, gneg, lat);
        check("s_m1_bcd", got, 12'h001);
        check("s_m1_neg", gneg, 1'b1);
        do_conv(8'h7F, got, gneg, lat);
        check("s_max_bcd", got, 12'h127);
        check("s_max_neg", gneg, 1'b0);
`endif

        for (int v = 0; v < 2**N; v++) begin
            do_conv(N'(v), got, gneg, lat);
            check($sformatf("sweep_bcd_%0d", v), got, ref_bcd(ref_mag(N'(v))));
            check($sformatf("sweep_neg_%0d", v), gneg, ref_neg(N'(v)));
            check($sformatf("sweep_digits_%0d", v), digits_ok(got), 1'b1);
            check($sformatf("sweep_lat_%0d", v), lat, LAT);
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
